amba_bus_master: RTL and testbench
==================================

# amba_bus_master

Initiator for the 128-bit AES key/data slave port: accepts one host command at a time (key write, data write, data read), drives the slave's one-hot enable strobes and HWDATA with the fixed cycle timing the slave expects, captures HRDATA on reads, and returns a single response with error status. It sits between the AES control sequencer (host side) and the AMBA slave/SRAM wrapper (bus side).

## Interface
- WR_LAT, 2: wait cycles after the strobe cycle for a write to complete.
- RD_LAT, 3: wait cycles after the strobe cycle until HRDATA is valid. Capture happens on the last wait cycle.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=KEY_WR, 1=DATA_WR, 2=DATA_RD, 3=reserved.
- cmd_data  in  128  write payload; ignored for DATA_RD.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  128  read data; 0 for writes and errors.
- rsp_err  out  1  HRESP seen during transfer, or reserved op.
- writek_enable / writed_enable / readd_enable  out  1 each  one-cycle strobes to slave.
- HWDATA  out  128  write data to slave.
- HRDATA  in  128  read data from slave.
- HRESP  in  1  slave error response.
- HREADYOUT  in  1  slave ready; unused by transfer timing, OR'd into error only if high during REQ (slave in HREADY state = busy).

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch op and data; go to REQ.
  - Reserved op goes straight to RESP with rsp_err=1 and causes no bus activity.
- REQ (1 cycle):
  - Assert exactly one strobe matching op.
  - Drive HWDATA=latched data for writes, 0 for reads.
  - Load counter with WR_LAT or RD_LAT; go to WAIT.
- WAIT:
  - Strobes low; HWDATA held (writes).
  - Counter decrements each cycle. At count==1 this is the last cycle; for reads, capture HRDATA into rsp_data on that edge. Then go to RESP.
- RESP:
  - rsp_valid=1, HWDATA=0.
  - On rsp_ready, go to IDLE.
  - rsp_valid and rsp_ready in the same cycle as entry completes the response in one cycle.
- Error flag:
  - Cleared on command accept.
  - Set if HRESP=1 in any REQ or WAIT cycle, or if HREADYOUT=1 during REQ.
  - If set at RESP, rsp_err=1 and rsp_data=0, discarding captured data.
- cmd_valid is ignored outside IDLE; the host must hold it until cmd_ready.

## Timing
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, all strobes 0, HWDATA=0, counter 0.
- Command accepted at edge E0. REQ occupies cycle 1, when the slave sees the strobe.
  - Writes: slave SETUP in cycle 2, WRITE in cycle 3. Master RESP from cycle 4 = 1+WR_LAT+1.
  - Reads: slave SETUP in cycle 2, READ in cycle 3, DISPLAY in cycle 4. HRDATA captured at end of cycle 4. RESP from cycle 5.
- Minimum command-to-command spacing with rsp_ready tied high:
  - 5 cycles for writes.
  - 6 cycles for reads.
  - This guarantees the slave is back in IDLE before the next strobe.
- rst asserted mid-transfer: all outputs return to reset values on the next edge; any pending response is lost.

## Structure
- Package amba_bus_pkg holds:
  - op enum (KEY_WR, DATA_WR, DATA_RD, OP_RSVD).
  - state enum.
  - default WR_LAT/RD_LAT constants.
  - DATA_W=128.
- One sub-module: bus_wait_counter, a loadable down-counter with a synchronous active-high reset and a `last` flag.
- FSM, latches and the error flag live in the top module.

## Test plan
- KEY_WR, cmd_data=128'hDEADBEEF…, rsp_ready=1:
  - writek_enable high only in cycle 1.
  - HWDATA equals the payload in cycles 1-3 and is 0 from cycle 4.
  - rsp_valid in cycle 4 with rsp_err=0.
- DATA_RD with the slave model returning 128'h0123…CDEF during cycle 4:
  - readd_enable high only in cycle 1.
  - rsp_data=0123…CDEF and rsp_valid in cycle 5.
- HRESP pulsed in cycle 3 of a DATA_WR: rsp_err=1 and rsp_data=0. The next command returns rsp_err=0.
- cmd_op=3: no strobe ever, rsp_valid the cycle after accept, rsp_err=1.
- rsp_ready held low for 4 cycles: rsp_valid and rsp_data stable, cmd_ready=0, new cmd_valid ignored. Accept on release.
- rst asserted in WAIT of a read: next cycle all outputs at reset values and cmd_ready=1. A following KEY_WR completes normally.

Source files
------------

// File: rtl/amba_bus_pkg.sv
// Shared types and constants for the AES slave-port bus master.
// Op codes match the host cmd_op encoding; latencies are cycles after the strobe cycle.
package amba_bus_pkg;

  localparam int DATA_W     = 128;
  localparam int WR_LAT_DEF = 2;
  localparam int RD_LAT_DEF = 3;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    OP_KEY_WR  = 2'd0,
    OP_DATA_WR = 2'd1,
    OP_DATA_RD = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic is_write(input op_e op);
    return (op == OP_KEY_WR) || (op == OP_DATA_WR);
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable down-counter that saturates at zero; last_o marks the final wait cycle.
module bus_wait_counter
  import amba_bus_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         srst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         last_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == W'(1));

endmodule

// File: rtl/amba_bus_master.sv
// Single-outstanding command initiator for the AES key/data slave: one strobe cycle,
// a fixed wait window, then a held response carrying read data or an error.
module amba_bus_master
  import amba_bus_pkg::*;
#(
  parameter int WR_LAT = WR_LAT_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              writek_enable,
  output logic              writed_enable,
  output logic              readd_enable,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HRESP,
  input  logic              HREADYOUT
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_last;

  bus_wait_counter #(
    .W (CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .srst_i     (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_KEY_WR;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          data_d  = cmd_data;
          rdata_d = '0;
          // A reserved op never touches the bus; it reports an error immediately.
          err_d   = (op_e'(cmd_op) == OP_RSVD);
          state_d = (op_e'(cmd_op) == OP_RSVD) ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_load = 1'b1;
        cnt_val  = (op_q == OP_DATA_RD) ? CNT_W'(RD_LAT) : CNT_W'(WR_LAT);
        if (HRESP || HREADYOUT) begin
          err_d = 1'b1;
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (HRESP) begin
          err_d = 1'b1;
        end
        if (cnt_last) begin
          if (op_q == OP_DATA_RD) begin
            rdata_d = HRDATA;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_err       = (state_q == ST_RESP) && err_q;
  assign rsp_data      = ((state_q == ST_RESP) && !err_q) ? rdata_q : '0;
  assign writek_enable = (state_q == ST_REQ) && (op_q == OP_KEY_WR);
  assign writed_enable = (state_q == ST_REQ) && (op_q == OP_DATA_WR);
  assign readd_enable  = (state_q == ST_REQ) && (op_q == OP_DATA_RD);
  assign HWDATA        = (((state_q == ST_REQ) || (state_q == ST_WAIT)) && is_write(op_q))
                         ? data_q : '0;

endmodule

// File: tb/tb_amba_bus_master.sv
// Bench for amba_bus_master: transaction-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then a long randomized run.
module tb_amba_bus_master;

  localparam int WR_LAT = 2;
  localparam int RD_LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic [127:0] cmd_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         writek_enable, writed_enable, readd_enable;
  logic [127:0] HWDATA;
  logic [127:0] HRDATA = '0;
  logic         HRESP = 1'b0;
  logic         HREADYOUT = 1'b0;

  always #5 clk = ~clk;

  amba_bus_master #(.WR_LAT(WR_LAT), .RD_LAT(RD_LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .writek_enable (writek_enable),
    .writed_enable (writed_enable),
    .readd_enable  (readd_enable),
    .HWDATA        (HWDATA),
    .HRDATA        (HRDATA),
    .HRESP         (HRESP),
    .HREADYOUT     (HREADYOUT)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: a command is a timeline counted from its accept edge.
  // Cycle 1 carries the strobe, the response begins at a fixed offset per op.
  function automatic int resp_at(input logic [1:0] op);
    if (op == 2'd3) return 1;
    if (op == 2'd2) return RD_LAT + 2;
    return WR_LAT + 2;
  endfunction

  bit           m_valid = 0;
  bit           m_busy = 0;
  int           m_t = 0;
  logic [1:0]   m_op = 2'd0;
  logic [127:0] m_data = '0;
  logic [127:0] m_rdata = '0;
  bit           m_err = 0;
  int           n_txn = 0;
  bit           e_resp;
  bit           e_wr;

  always @(negedge clk) begin
    e_resp = m_busy && (m_t >= resp_at(m_op));
    e_wr   = m_busy && (m_op == 2'd0 || m_op == 2'd1);
    if (m_valid) begin
      chk1("cmd_ready", cmd_ready, !m_busy);
      chk1("rsp_valid", rsp_valid, e_resp);
      chk1("rsp_err", rsp_err, e_resp && m_err);
      chk128("rsp_data", rsp_data, (e_resp && !m_err) ? m_rdata : 128'd0);
      chk1("writek_enable", writek_enable, m_busy && m_t == 1 && m_op == 2'd0);
      chk1("writed_enable", writed_enable, m_busy && m_t == 1 && m_op == 2'd1);
      chk1("readd_enable", readd_enable, m_busy && m_t == 1 && m_op == 2'd2);
      chk128("HWDATA", HWDATA, (e_wr && m_t >= 1 && m_t <= 1 + WR_LAT) ? m_data : 128'd0);
    end
    if (rst) begin
      m_valid = 1;
      m_busy  = 0;
    end else if (m_valid) begin
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy  = 1;
          m_t     = 1;
          m_op    = cmd_op;
          m_data  = cmd_data;
          m_rdata = '0;
          m_err   = (cmd_op == 2'd3);
        end
      end else if (e_resp) begin
        if (rsp_ready) begin
          m_busy = 0;
          n_txn++;
          $display("txn %0d op=%0d err=%0b data=%h", n_txn, m_op, m_err,
                   m_err ? 128'd0 : m_rdata);
        end
      end else begin
        if (HRESP) m_err = 1;
        if (m_t == 1 && HREADYOUT) m_err = 1;
        if (m_op == 2'd2 && m_t == 1 + RD_LAT) m_rdata = HRDATA;
        m_t++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (strobe cycle) of the issued command.
  task automatic issue(input logic [1:0] op, input logic [127:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk1("issue_ready_timeout", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  localparam logic [127:0] KEY_P = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] RD_P  = 128'h0123456789ABCDEF0123456789ABCDEF;

  initial begin
    logic [127:0] rd_a;
    repeat (3) tick();
    chk1("reset_cmd_ready", cmd_ready, 1'b1);
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk128("reset_rsp_data", rsp_data, 128'd0);
    chk128("reset_hwdata", HWDATA, 128'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();

    // KEY_WR timing
    issue(2'd0, KEY_P);
    chk1("kw_strobe_c1", writek_enable, 1'b1);
    chk128("kw_hwdata_c1", HWDATA, KEY_P);
    tick();
    chk1("kw_strobe_c2", writek_enable, 1'b0);
    chk128("kw_hwdata_c2", HWDATA, KEY_P);
    tick();
    chk128("kw_hwdata_c3", HWDATA, KEY_P);
    chk1("kw_rsp_valid_c3", rsp_valid, 1'b0);
    tick();
    chk1("kw_rsp_valid_c4", rsp_valid, 1'b1);
    chk1("kw_rsp_err_c4", rsp_err, 1'b0);
    chk128("kw_hwdata_c4", HWDATA, 128'd0);
    tick();

    // DATA_RD capture: valid read data only during cycle 4
    HRDATA = rnd128();
    issue(2'd2, rnd128());
    chk1("rd_strobe_c1", readd_enable, 1'b1);
    tick();
    HRDATA = rnd128();
    chk1("rd_strobe_c2", readd_enable, 1'b0);
    tick();
    HRDATA = rnd128();
    tick();
    HRDATA = RD_P;
    chk1("rd_rsp_valid_c4", rsp_valid, 1'b0);
    tick();
    HRDATA = rnd128();
    chk1("rd_rsp_valid_c5", rsp_valid, 1'b1);
    chk128("rd_rsp_data_c5", rsp_data, RD_P);
    tick();

    // HRESP in cycle 3 of a DATA_WR, then a clean command
    issue(2'd1, rnd128());
    tick();
    tick();
    HRESP = 1'b1;
    tick();
    HRESP = 1'b0;
    chk1("err_rsp_err", rsp_err, 1'b1);
    chk128("err_rsp_data", rsp_data, 128'd0);
    tick();
    issue(2'd0, rnd128());
    tick();
    tick();
    tick();
    chk1("after_err_valid", rsp_valid, 1'b1);
    chk1("after_err_rsp_err", rsp_err, 1'b0);
    tick();

    // Reserved op
    issue(2'd3, rnd128());
    chk1("rsvd_rsp_valid", rsp_valid, 1'b1);
    chk1("rsvd_rsp_err", rsp_err, 1'b1);
    chk1("rsvd_no_strobe", writek_enable | writed_enable | readd_enable, 1'b0);
    tick();

    // Response back-pressure
    rsp_ready = 1'b0;
    rd_a = rnd128();
    HRDATA = rd_a;
    issue(2'd2, rnd128());
    repeat (4) tick();
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_data  = KEY_P;
    for (int i = 0; i < 4; i++) begin
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk128("bp_rsp_data", rsp_data, rd_a);
      chk1("bp_cmd_ready", cmd_ready, 1'b0);
      chk1("bp_no_strobe", writek_enable, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk1("bp_release_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk1("bp_accept_strobe", writek_enable, 1'b1);
    repeat (4) tick();

    // Reset during a read's wait window
    issue(2'd2, rnd128());
    tick();
    rst = 1'b1;
    tick();
    chk1("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk1("mid_rst_rsp_err", rsp_err, 1'b0);
    chk128("mid_rst_rsp_data", rsp_data, 128'd0);
    chk1("mid_rst_strobes", writek_enable | writed_enable | readd_enable, 1'b0);
    chk128("mid_rst_hwdata", HWDATA, 128'd0);
    rst = 1'b0;
    issue(2'd0, KEY_P);
    chk1("post_rst_strobe", writek_enable, 1'b1);
    tick();
    tick();
    tick();
    chk1("post_rst_valid", rsp_valid, 1'b1);
    chk1("post_rst_err", rsp_err, 1'b0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = rnd128();
      rsp_ready = ($urandom_range(0, 2) != 0);
      HRESP     = ($urandom_range(0, 15) == 0);
      HREADYOUT = ($urandom_range(0, 15) == 0);
      HRDATA    = rnd128();
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    HRESP     = 1'b0;
    HREADYOUT = 1'b0;
    rst       = 1'b0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
